// File: rtl/sar_adc_scheduler_pkg.sv
// sar_sched_pkg: shared state type and defaults for the SAR ADC scheduler
package sar_sched_pkg;
    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, RESP} sched_state_t;
    localparam int DEF_N_CH = 4;
    localparam int DEF_N_BITS = 10;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/sar_adc_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or above ptr with wrap
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);
    logic [W-1:0] idx;
    // scan from farthest to nearest offset so the nearest set request overwrites
    always_comb begin
        gnt_onehot = '0;
        gnt_idx = '0;
        gnt_valid = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(ptr) + i) % N);
            if (en && req[idx]) begin
                gnt_idx = idx;
                gnt_valid = 1'b1;
            end
        end
        if (gnt_valid) gnt_onehot[gnt_idx] = 1'b1;
    end
endmodule

// File: rtl/sar_adc_scheduler.sv
// sar_adc_scheduler: round-robin sharing of one SAR ADC with sample, convert and timeout sequencing
module sar_adc_scheduler
    import sar_sched_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int N_BITS = DEF_N_BITS,
    parameter int SAMPLE_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_CH-1:0]   req_valid,
    output logic [N_CH-1:0]   req_ack,
    output logic [CH_W-1:0]   adc_mux_sel,
    output logic              adc_hold,
    input  logic              adc_eoc,
    input  logic [N_BITS-1:0] adc_result,
    output logic              rsp_valid,
    output logic [CH_W-1:0]   rsp_ch,
    output logic [N_BITS-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic              busy
);
    localparam int CNT_W = $clog2(max_int(SAMPLE_CYCLES, TIMEOUT_CYCLES));

    sched_state_t      state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   mux_sel_q, mux_sel_d;
    logic              hold_q, hold_d;
    logic              eoc_q, eoc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [CH_W-1:0]   rsp_ch_q, rsp_ch_d;
    logic [N_BITS-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [N_CH-1:0]   gnt_onehot;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_valid;
    logic              arb_en;
    logic              eoc_rise;

    // grants only happen from IDLE, and never while reset is held
    assign arb_en = enable && (state_q == IDLE) && !reset;
    assign eoc_rise = adc_eoc && !eoc_q;

    rr_arbiter #(.N(N_CH), .W(CH_W)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .en        (arb_en),
        .gnt_onehot(gnt_onehot),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // next-state, counter and response capture for the conversion sequence
    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d = cnt_q;
        mux_sel_d = mux_sel_q;
        rsp_ch_d = rsp_ch_q;
        rsp_data_d = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        eoc_d = adc_eoc;
        case (state_q)
            IDLE: if (gnt_valid) begin
                mux_sel_d = gnt_idx;
                rr_ptr_d = CH_W'((int'(gnt_idx) + 1) % N_CH);
                cnt_d = CNT_W'(SAMPLE_CYCLES - 1);
                state_d = SAMPLE;
            end
            SAMPLE: begin
                cnt_d = (cnt_q == '0) ? CNT_W'(TIMEOUT_CYCLES - 1) : cnt_q - CNT_W'(1);
                state_d = (cnt_q == '0) ? CONVERT : SAMPLE;
            end
            CONVERT: begin
                if (eoc_rise || cnt_q == '0) begin
                    rsp_ch_d = mux_sel_q;
                    rsp_data_d = eoc_rise ? adc_result : '0;
                    rsp_timeout_d = !eoc_rise;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        hold_d = (state_d == CONVERT);
        rsp_valid_d = (state_d == RESP);
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            cnt_q <= '0;
            mux_sel_q <= '0;
            hold_q <= 1'b0;
            eoc_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_ch_q <= '0;
            rsp_data_q <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q <= cnt_d;
            mux_sel_q <= mux_sel_d;
            hold_q <= hold_d;
            eoc_q <= eoc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ch_q <= rsp_ch_d;
            rsp_data_q <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ack = gnt_onehot;
    assign adc_mux_sel = mux_sel_q;
    assign adc_hold = hold_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ch = rsp_ch_q;
    assign rsp_data = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy = (state_q != IDLE);
endmodule

// File: doc/sar_adc_scheduler.md
Name: sar_adc_scheduler

Overview:
- Shares one sar_adc__N_BITS_10 instance between N_CH requesters using round-robin arbitration.
- For each accepted request it sequences a full conversion:
  - select the analog mux channel,
  - let the mux settle and track,
  - assert hold,
  - wait for end-of-conversion, with a timeout,
  - return the tagged result.
- Sits between the sampling clients and the ADC/analog-mux pair, in the clk domain.

Parameters:
- N_CH, 4, number of requesting channels (≥2).
- N_BITS, 10, ADC result width.
- SAMPLE_CYCLES, 8, clk cycles of mux settle/track (adc_hold low) before hold (≥1).
- TIMEOUT_CYCLES, 4096, max clk cycles in CONVERT waiting for eoc rising edge (≥2).
- CH_W, $clog2(N_CH), channel index width (derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new grants; an in-flight conversion completes.
- req_valid  in  N_CH  per-channel conversion request (level).
- req_ack  out  N_CH  one-hot, 1-cycle pulse: request accepted.
- adc_mux_sel  out  CH_W  analog mux channel select.
- adc_hold  out  1  drives ADC input_hold_digital; 1 = hold/convert.
- adc_eoc  in  1  ADC end-of-conversion.
- adc_result  in  N_BITS  ADC parallel result.
- rsp_valid  out  1  1-cycle pulse: response available.
- rsp_ch  out  CH_W  channel of the response.
- rsp_data  out  N_BITS  conversion result (0 on timeout).
- rsp_timeout  out  1  response is a timeout, qualified by rsp_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:

Reset (asynchronous, active-high), all outputs 0:
- state = IDLE
- rr_ptr = 0
- adc_hold, req_ack, rsp_valid, rsp_ch, rsp_data, rsp_timeout, adc_mux_sel, busy all 0
- eoc_q = 1, so an eoc already high after reset is not taken as an edge

Reset mid-conversion aborts it with no response.

FSM states: IDLE, SAMPLE, CONVERT, RESP.

IDLE:
- If enable && |req_valid, grant the first set bit searching from rr_ptr upward with wrap.
  - Pulse req_ack[g] for that cycle.
  - Register adc_mux_sel = g.
  - Set rr_ptr = (g+1) mod N_CH.
  - Load counter = SAMPLE_CYCLES-1.
  - Go to SAMPLE.
- Otherwise stay in IDLE.
- req_ack is combinational from the IDLE decision and is never asserted outside IDLE.

SAMPLE:
- adc_hold = 0; adc_mux_sel stable.
- Decrement the counter; at 0 go to CONVERT and load the counter with TIMEOUT_CYCLES-1.
- Result: exactly SAMPLE_CYCLES cycles in SAMPLE.

CONVERT:
- adc_hold = 1 (registered).
- eoc_rise = adc_eoc && !eoc_q, where eoc_q is adc_eoc registered every cycle.
- On eoc_rise: capture adc_result into rsp_data, set rsp_timeout = 0, go to RESP.
- Else, if the counter is 0: rsp_data = 0, rsp_timeout = 1, go to RESP.
- Else decrement the counter.
- If eoc_rise and counter == 0 occur in the same cycle, eoc wins (valid data).

RESP:
- rsp_valid = 1 for exactly one cycle.
- rsp_ch = the granted channel.
- adc_hold returns to 0.
- Go to IDLE. A new grant is possible on the following cycle.

Outputs and hold data:
- rsp_ch, rsp_data and rsp_timeout hold their values until the next RESP.
- adc_mux_sel holds its value until the next grant.

Minimum latency from grant (req_ack) to rsp_valid:
- SAMPLE_CYCLES + 1 + (cycles until eoc rise) + 1.

Other rules:
- enable falling mid-conversion has no effect until the return to IDLE.
- req_valid dropping after req_ack has no effect; the conversion completes.
- A channel holding req_valid high is re-granted only after all other requesting channels have been served.

Decomposition:
- Package sar_sched_pkg:
  - state enum sched_state_t {IDLE, SAMPLE, CONVERT, RESP};
  - localparam defaults for N_CH and N_BITS.
- One sub-module, rr_arbiter:
  - parameter N;
  - inputs req[N], ptr[$clog2(N)], en;
  - outputs gnt_onehot, gnt_idx, gnt_valid;
  - purely combinational priority rotation.
- The FSM, counters and eoc edge detect stay in sar_adc_scheduler.

Test Plan:
1. Single request: N_CH=4, SAMPLE_CYCLES=8; req_valid=4'b0100; eoc rises 20 cycles after adc_hold rises, adc_result=10'h2A5 -> the following must all hold:
   - req_ack=4'b0100 for 1 cycle;
   - adc_mux_sel=2;
   - adc_hold low for 8 cycles, then high;
   - rsp_valid 1 cycle with rsp_ch=2, rsp_data=10'h2A5, rsp_timeout=0.
2. Round-robin fairness: req_valid=4'b1111 held constant -> grants in order 0,1,2,3,0. No channel is granted twice before the others are served.
3. Timeout: TIMEOUT_CYCLES=16, adc_eoc held 0 -> rsp_valid exactly 16 cycles after entering CONVERT, with rsp_timeout=1 and rsp_data=0. The next request is served normally.
4. Stuck-high eoc: adc_eoc=1 through reset and into CONVERT -> no false completion. Completion occurs only after eoc falls and rises again, or on timeout.
5. Async reset mid-CONVERT: assert reset between clock edges -> all outputs 0 immediately; no rsp_valid. After release with req_valid=4'b0001, channel 0 is granted (rr_ptr=0).
6. enable gating: drop enable during SAMPLE with req_valid=4'b0011 pending -> the current conversion completes with rsp_valid. No further req_ack until enable=1, then channel 1 is granted if channel 0 was just served.
